// File: rtl/otter_csr_pkg.sv
// Shared definitions for the OTTER machine-mode CSR / interrupt logic:
// CSR addresses, mstatus bit positions, the CSR op encoding, the CSR
// request payload and the read-modify-write helper.
package otter_csr_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] MCAUSE_EXT_INT = 32'h8000_000B;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // Encoding matches ir[13:12] of the CSR instruction.
  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_RW  = 2'b01,
    CSR_RS  = 2'b10,
    CSR_RC  = 2'b11
  } csr_op_t;

  // One CSR access as presented by CU_FSM.
  typedef struct packed {
    logic              we;
    csr_op_t           op;
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   wd;
  } csr_req_t;

  // Value a CSR takes after the given op is applied to its old contents.
  function automatic logic [XLEN-1:0] csr_apply(input csr_op_t         op,
                                                input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] wd);
    logic [XLEN-1:0] res;
    case (op)
      CSR_RW:  res = wd;
      CSR_RS:  res = old_val | wd;
      CSR_RC:  res = old_val & ~wd;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/otter_sync_edge.sv
// N-flop synchronizer with a rising-edge detector on the synchronized level.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized level (registered)
//   rise_c     : combinational one-cycle pulse when q goes 0 -> 1
module otter_sync_edge #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c
);

  // Fewer than two flops is not a safe synchronizer; clamp silently.
  localparam int unsigned STAGES = (N < 2) ? 2 : N;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift chain plus one extra flop holding the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_intr_csr_ctrl.sv
// Machine-mode interrupt and CSR controller for the OTTER MCU.
// Owns mstatus (MIE/MPIE), mtvec, mepc and mcause, synchronizes the external
// interrupt line and applies trap-entry / mret updates pulsed by CU_FSM.
// Build option: define OTTER_INTR_LEVEL_EN for level-sensitive interrupts
// (pending follows the synchronized INTR level); default is edge capture.
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   INTR                  : external interrupt, asynchronous to CLK
//   csr_WE/op/addr/wd     : CSR access from CU_FSM
//   pc_in                 : current PC, saved to mepc on trap entry
//   int_taken, mret_exec  : trap-entry / mret pulses from CU_FSM
//   int_req               : pending interrupt AND mstatus.MIE
//   csr_RD                : combinational read data for csr_addr
//   MTVEC, MEPC           : trap vector / return address to the PC mux
//   mie_o                 : mstatus.MIE
module otter_intr_csr_ctrl
  import otter_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INTR,
  input  logic        csr_WE,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  input  logic [31:0] pc_in,
  input  logic        int_taken,
  input  logic        mret_exec,
  output logic        int_req,
  output logic [31:0] csr_RD,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC,
  output logic        mie_o
);

  csr_req_t        csr_req;
  logic            csr_wr_en;
  logic [XLEN-1:0] csr_rd_val;
  logic [XLEN-1:0] csr_wr_val;
  logic [XLEN-1:0] mstatus_rd;

  logic            mie_q,    mie_d;
  logic            mpie_q,   mpie_d;
  logic [XLEN-1:0] mtvec_q,  mtvec_d;
  logic [XLEN-1:0] mepc_q,   mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic            sync_level;
  logic            sync_rise_c;
  logic            pending;
  logic            sync_unused;
  logic            pc_unused;

  assign csr_req.we   = csr_WE;
  assign csr_req.op   = csr_op_t'(csr_op);
  assign csr_req.addr = csr_addr;
  assign csr_req.wd   = csr_wd;

  // The PC is word aligned on trap entry; its low bits are never stored.
  assign pc_unused = ^pc_in[1:0];

  // External interrupt synchronizer.
  otter_sync_edge #(
    .N (SYNC_STAGES)
  ) u_intr_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .d      (INTR),
    .q      (sync_level),
    .rise_c (sync_rise_c)
  );

`ifdef OTTER_INTR_LEVEL_EN
  // Level mode: the request follows the synchronized line directly.
  assign pending     = sync_level;
  assign sync_unused = sync_rise_c;
`else
  logic pending_q, pending_d;

  // Edge mode: a rising edge latches pending until the trap is taken. An edge
  // arriving in the trap-entry cycle re-arms pending so it is not lost.
  always_comb begin
    pending_d = pending_q | sync_rise_c;
    if (int_taken) begin
      pending_d = sync_rise_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending     = pending_q;
  assign sync_unused = sync_level;
`endif

  // mstatus view: only MIE and MPIE are implemented, the rest reads zero.
  always_comb begin
    mstatus_rd                   = '0;
    mstatus_rd[MSTATUS_MIE_BIT]  = mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mpie_q;
  end

  // Zero-latency CSR read; unmapped addresses read zero.
  always_comb begin
    csr_rd_val = '0;
    case (csr_req.addr)
      CSR_MSTATUS: csr_rd_val = mstatus_rd;
      CSR_MTVEC:   csr_rd_val = mtvec_q;
      CSR_MEPC:    csr_rd_val = mepc_q;
      CSR_MCAUSE:  csr_rd_val = mcause_q;
      default:     csr_rd_val = '0;
    endcase
  end

  assign csr_wr_en  = csr_req.we & (csr_req.op != CSR_NOP);
  assign csr_wr_val = csr_apply(csr_req.op, csr_rd_val, csr_req.wd);

  // Next-state for the CSRs. Updates are applied lowest priority first so
  // that mret overrides a CSR write and trap entry overrides both.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;

    if (csr_wr_en) begin
      case (csr_req.addr)
        CSR_MSTATUS: begin
          mie_d  = csr_wr_val[MSTATUS_MIE_BIT];
          mpie_d = csr_wr_val[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:  mtvec_d  = {csr_wr_val[XLEN-1:2], 2'b00};
        CSR_MEPC:   mepc_d   = {csr_wr_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_wr_val;
        default: ;
      endcase
    end

    if (mret_exec) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (int_taken) begin
      mepc_d   = {pc_in[XLEN-1:2], 2'b00};
      mcause_d = MCAUSE_EXT_INT;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  // CSR state registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  assign int_req = pending & mie_q;
  assign csr_RD  = csr_rd_val;
  assign MTVEC   = mtvec_q;
  assign MEPC    = mepc_q;
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_otter_intr_csr_ctrl.sv
// Bench for otter_intr_csr_ctrl: directed vector table, an interrupt latency
// sequence, then randomized traffic checked against a behavioural model.
module tb_otter_intr_csr_ctrl;

  localparam int unsigned SYNC = 2;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        intr = 1'b0;
  logic        csr_we = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wd = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic        int_taken = 1'b0;
  logic        mret_exec = 1'b0;
  logic        int_req;
  logic [31:0] csr_rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie_o;

  int n_checks = 0;
  int n_errors = 0;

  otter_intr_csr_ctrl #(
    .MTVEC_RST   (32'h0000_0000),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .INTR      (intr),
    .csr_WE    (csr_we),
    .csr_op    (csr_op),
    .csr_addr  (csr_addr),
    .csr_wd    (csr_wd),
    .pc_in     (pc_in),
    .int_taken (int_taken),
    .mret_exec (mret_exec),
    .int_req   (int_req),
    .csr_RD    (csr_rd),
    .MTVEC     (mtvec),
    .MEPC      (mepc),
    .mie_o     (mie_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, intr, we;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd, pc;
    logic        tk, mr;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_req;
    logic [31:0] exp_mtvec, exp_mepc;
    logic        exp_mie;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic i, input logic we,
                              input logic [1:0] op, input logic [11:0] a,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic tk, input logic mr, input logic c,
                              input logic [31:0] rd, input logic req,
                              input logic [31:0] tv, input logic [31:0] ep,
                              input logic mie);
    vec_t v;
    v.rst_n = r; v.intr = i; v.we = we; v.op = op; v.addr = a; v.wd = wd;
    v.pc = pc; v.tk = tk; v.mr = mr; v.chk_rd = c; v.exp_rd = rd;
    v.exp_req = req; v.exp_mtvec = tv; v.exp_mepc = ep; v.exp_mie = mie;
    return v;
  endfunction

  task automatic fill_vectors();
    //                 rst intr we op     addr     wd            pc         tk mr  chk rd            req mtvec        mepc       mie
    vecs.push_back(mk(L, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  L, 32'h0,        L, 32'h0,    32'h0,   L)); // 0 reset
    vecs.push_back(mk(L, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h0,        L, 32'h0,    32'h0,   L)); // 1 reset
    vecs.push_back(mk(H, L, H, 2'd1, 12'h305, 32'h1003,     32'h0,     L, L,  H, 32'h0,        L, 32'h1000, 32'h0,   L)); // 2 write mtvec
    vecs.push_back(mk(H, L, H, 2'd2, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h0,        L, 32'h1000, 32'h0,   H)); // 3 set MIE
    vecs.push_back(mk(H, L, H, 2'd3, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h8,        L, 32'h1000, 32'h0,   L)); // 4 clear MIE
    vecs.push_back(mk(H, L, H, 2'd2, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h0,        L, 32'h1000, 32'h0,   H)); // 5 set MIE
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h8,        L, 32'h1000, 32'h0,   H)); // 6 INTR pulse
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h8,        L, 32'h1000, 32'h0,   H)); // 7
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h8,        H, 32'h1000, 32'h0,   H)); // 8 req after 3
    vecs.push_back(mk(H, L, L, 2'd0, 12'h342, 32'h0,        32'h124,   H, L,  H, 32'h0,        L, 32'h1000, 32'h124, L)); // 9 trap
    vecs.push_back(mk(H, L, L, 2'd0, 12'h342, 32'h0,        32'h0,     L, L,  H, 32'h8000000B, L, 32'h1000, 32'h124, L)); // 10 mcause
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h124, L)); // 11 MPIE=1
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, H,  H, 32'h80,       L, 32'h1000, 32'h124, H)); // 12 mret
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h88,       L, 32'h1000, 32'h124, H)); // 13
    vecs.push_back(mk(H, L, H, 2'd3, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h88,       L, 32'h1000, 32'h124, L)); // 14 mask
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h124, L)); // 15
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h124, L)); // 16
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h124, L)); // 17 pending, masked
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h124, L)); // 18
    vecs.push_back(mk(H, L, H, 2'd2, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h80,       H, 32'h1000, 32'h124, H)); // 19 unmask
    vecs.push_back(mk(H, L, H, 2'd1, 12'h300, 32'h0,        32'h200,   H, L,  H, 32'h88,       L, 32'h1000, 32'h200, L)); // 20 trap beats write
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h200, L)); // 21 MPIE=1
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h200, L)); // 22
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h200, L)); // 23
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h1000, 32'h200, L)); // 24 pending
    vecs.push_back(mk(L, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h80,       L, 32'h0,    32'h0,   L)); // 25 reset
    vecs.push_back(mk(H, L, H, 2'd2, 12'h300, 32'h8,        32'h0,     L, L,  H, 32'h0,        L, 32'h0,    32'h0,   H)); // 26 no stale req
    vecs.push_back(mk(H, L, L, 2'd0, 12'h7C0, 32'h0,        32'h0,     L, L,  H, 32'h0,        L, 32'h0,    32'h0,   H)); // 27 unmapped
    vecs.push_back(mk(H, L, H, 2'd1, 12'h7C0, 32'hFFFFFFFF, 32'h0,     L, L,  H, 32'h0,        L, 32'h0,    32'h0,   H)); // 28 ignored write
    vecs.push_back(mk(H, L, L, 2'd0, 12'h7C0, 32'h0,        32'h0,     L, L,  H, 32'h0,        L, 32'h0,    32'h0,   H)); // 29
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h8,        L, 32'h0,    32'h0,   H)); // 30
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h8,        L, 32'h0,    32'h0,   H)); // 31
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h300,   H, L,  H, 32'h8,        L, 32'h0,    32'h300, L)); // 32 edge + trap
    vecs.push_back(mk(H, H, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, H,  H, 32'h80,       H, 32'h0,    32'h300, H)); // 33 pending kept
    vecs.push_back(mk(H, L, L, 2'd0, 12'h300, 32'h0,        32'h0,     L, L,  H, 32'h88,       H, 32'h0,    32'h300, H)); // 34
  endtask

  task automatic drive(input logic r, input logic i, input logic we, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc,
                       input logic tk, input logic mr);
    rst_n = r; intr = i; csr_we = we; csr_op = op; csr_addr = a;
    csr_wd = wd; pc_in = pc; int_taken = tk; mret_exec = mr;
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_mie, m_mpie, m_pending;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic        hist [0:SYNC];   // hist[0] = INTR at the most recent clock edge

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] nv;
    logic        rise, o_mie, o_mpie;
    if (!rst_n) begin
      m_mie = 1'b0; m_mpie = 1'b0; m_pending = 1'b0;
      m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
      for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
    end else begin
      // The synchronized line lags INTR by SYNC edges; an edge on it is
      // seen one edge later as a 0->1 step between consecutive samples.
      rise   = hist[SYNC-1] & ~hist[SYNC];
      o_mie  = m_mie;
      o_mpie = m_mpie;
      if (csr_we && csr_op != 2'b00) begin
        case (csr_op)
          2'b01:   nv = csr_wd;
          2'b10:   nv = m_read(csr_addr) | csr_wd;
          default: nv = m_read(csr_addr) & ~csr_wd;
        endcase
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec  = nv & 32'hFFFF_FFFC;
          12'h341: m_mepc   = nv & 32'hFFFF_FFFC;
          12'h342: m_mcause = nv;
          default: ;
        endcase
      end
      if (mret_exec) begin
        m_mie  = o_mpie;
        m_mpie = 1'b1;
      end
      if (int_taken) begin
        m_mepc    = pc_in & 32'hFFFF_FFFC;
        m_mcause  = 32'h8000_000B;
        m_mpie    = o_mie;
        m_mie     = 1'b0;
        m_pending = 1'b0;
      end
      if (rise) m_pending = 1'b1;
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = intr;
    end
  endtask

  task automatic rnd_cycle(input logic force_rst);
    logic [11:0] addrs [0:4];
    int          sel;
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
    addrs[3] = 12'h342; addrs[4] = 12'h7C0;
    @(negedge clk);
    rst_n = force_rst ? 1'b0 : ($urandom_range(99) != 0);
    if ($urandom_range(5) == 0) intr = ~intr;
    csr_we    = ($urandom_range(2) == 0);
    csr_op    = 2'($urandom_range(3));
    sel       = int'($urandom_range(5));
    csr_addr  = (sel == 5) ? 12'($urandom) : addrs[sel];
    csr_wd    = $urandom;
    pc_in     = $urandom;
    int_taken = ($urandom_range(7) == 0);
    mret_exec = ($urandom_range(7) == 0);
    #1;
    if (rst_n) check("rnd csr_RD", csr_rd, m_read(csr_addr));
    @(posedge clk);
    model_step();
    #1;
    check("rnd int_req", 32'(int_req), 32'(m_pending & m_mie));
    check("rnd MTVEC", mtvec, m_mtvec);
    check("rnd MEPC", mepc, m_mepc);
    check("rnd mie_o", 32'(mie_o), 32'(m_mie));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    fill_vectors();

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].intr, vecs[i].we, vecs[i].op, vecs[i].addr,
            vecs[i].wd, vecs[i].pc, vecs[i].tk, vecs[i].mr);
      #1;
      if (vecs[i].chk_rd) check($sformatf("v%0d csr_RD", i), csr_rd, vecs[i].exp_rd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d int_req", i), 32'(int_req), 32'(vecs[i].exp_req));
      check($sformatf("v%0d MTVEC", i), mtvec, vecs[i].exp_mtvec);
      check($sformatf("v%0d MEPC", i), mepc, vecs[i].exp_mepc);
      check($sformatf("v%0d mie_o", i), 32'(mie_o), 32'(vecs[i].exp_mie));
    end

    // Edge-to-request latency, measured with a bounded wait.
    @(negedge clk); drive(L, L, L, 2'd0, 12'h300, 32'h0, 32'h0, L, L);
    @(negedge clk); drive(L, L, L, 2'd0, 12'h300, 32'h0, 32'h0, L, L);
    @(negedge clk); drive(H, L, H, 2'd2, 12'h300, 32'h8, 32'h0, L, L);
    @(negedge clk); drive(H, H, L, 2'd0, 12'h300, 32'h0, 32'h0, L, L);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) intr = 1'b0;
      if (int_req) begin
        lat = c;
        break;
      end
    end
    check("intr latency", 32'(lat), 32'(SYNC + 1));

    // Randomized traffic against the model, starting from reset.
    intr = 1'b0;
    rnd_cycle(1'b1);
    rnd_cycle(1'b1);
    for (int n = 0; n < 2000; n++) rnd_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/otter_intr_csr_ctrl.md
Name: otter_intr_csr_ctrl

Overview:
- Machine-mode interrupt and CSR controller for the OTTER MCU.
- Owns mstatus, mtvec, mepc and mcause; drives MTVEC/MEPC into the PC source mux and csr_RD into the register-file write mux.
- Synchronizes and latches the external INTR line and raises int_req to CU_FSM.
- Applies trap-entry and mret state updates when CU_FSM pulses int_taken / mret_exec.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- SYNC_STAGES, 2, flop count of the INTR synchronizer (minimum 2).

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  synchronous, active-low reset.
- INTR  input  1  external interrupt, asynchronous to CLK.
- csr_WE  input  1  CSR write strobe from CU_FSM, one cycle per CSR instruction.
- csr_op  input  2  ir[13:12]: 01 write, 10 set, 11 clear, 00 no write.
- csr_addr  input  12  ir[31:20].
- csr_wd  input  32  rs1 value.
- pc_in  input  32  current PC, captured into mepc on trap entry.
- int_taken  input  1  CU_FSM trap-entry pulse.
- mret_exec  input  1  CU_FSM mret pulse.
- int_req  output  1  pending AND mstatus.MIE, to CU_FSM.
- csr_RD  output  32  combinational read data for csr_addr.
- MTVEC  output  32  trap vector to the PC mux.
- MEPC  output  32  return address to the PC mux.
- mie_o  output  1  mstatus.MIE, for debug/IO.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - All synchronizer flops, pending, mstatus (MIE, MPIE), mepc and mcause are cleared to 0.
  - mtvec resets to MTVEC_RST.
  - Outputs are 0 on the following cycle, except MTVEC = MTVEC_RST.
  - Reset overrides every other input, including mid-trap.
- CSR map:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE, all other bits read 0.
  - 0x305 mtvec: bits[1:0] are forced to 0.
  - 0x341 mepc: bits[1:0] are forced to 0.
  - 0x342 mcause.
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: csr_RD is combinational, zero latency. It returns the pre-write (old) value during the write cycle.
- Writes: on csr_WE & (csr_op != 00), the register takes the new value at the next CLK edge.
  - write: new = csr_wd.
  - set: new = old | csr_wd.
  - clear: new = old & ~csr_wd.
- INTR capture:
  - INTR passes through the SYNC_STAGES-flop synchronizer.
  - A rising edge on the synchronized signal sets pending.
  - Edge-to-int_req latency: SYNC_STAGES+1 cycles when MIE = 1.
- Trap entry (int_taken = 1):
  - mepc <= {pc_in[31:2], 2'b00}.
  - mcause <= 32'h8000_000B.
  - MPIE <= MIE, MIE <= 0, pending <= 0.
- mret (mret_exec = 1): MIE <= MPIE, MPIE <= 1.
- Priority: reset > int_taken > mret_exec > csr_WE. Lower-priority updates to the same register are dropped in that cycle.
- Simultaneous events:
  - A new sync edge in the same cycle as int_taken leaves pending set, so the new edge is not lost.
  - Multiple edges while pending is already set collapse into one request.
- int_req is masked while MIE = 0; pending is retained.

Optional Feature:
- Macro OTTER_INTR_LEVEL_EN.
- Defined: pending is the synchronized INTR level, with no latch and no clear on int_taken. int_req = sync_intr & MIE.
- Undefined (default): rising-edge capture as above.

Decomposition:
- Package otter_csr_pkg holds:
  - CSR address localparams: CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE.
  - MCAUSE_EXT_INT = 32'h8000_000B.
  - MSTATUS_MIE_BIT = 3, MSTATUS_MPIE_BIT = 7.
  - typedef enum logic [1:0] csr_op_t {CSR_NOP, CSR_RW, CSR_RS, CSR_RC}.
- One sub-module, otter_sync_edge: parameterized N-flop synchronizer with a rising-edge pulse output. It is reused for future IO inputs.

Test Plan:
- Reset: hold RST_N = 0 for 2 cycles -> MTVEC = MTVEC_RST, MEPC = 0, csr_RD(0x300) = 0, int_req = 0.
- CSR ops:
  - write 0x305 <- 32'h0000_1003 -> MTVEC = 32'h0000_1000.
  - set 0x300 with 32'h8 -> mie_o = 1.
  - clear 0x300 with 32'h8 -> mie_o = 0.
- Interrupt flow:
  - MIE = 1, pulse INTR for 1 cycle -> int_req = 1 exactly 3 cycles later.
  - int_taken with pc_in = 32'h0000_0124 -> MEPC = 32'h124, csr_RD(0x342) = 32'h8000_000B, MIE = 0, MPIE = 1, int_req = 0.
- Masking: MIE = 0, INTR edge -> int_req stays 0. Then set MIE -> int_req = 1 the next cycle.
- mret: after trap, mret_exec -> MIE = 1, MPIE = 1. Also assert csr_WE writing 0x300 <- 0 in the same cycle as int_taken -> the trap update wins, MPIE = 1.
- Corner cases:
  - Sync edge coincident with int_taken -> pending still 1 afterwards.
  - RST_N low during pending -> int_req = 0 and no trap remains after reset.
  - Read of 0x7C0 -> 0.
